// File: rtl/ocext_arb_pkg.sv
// ocext_arb_pkg: shared state type and weight helpers for the weighted round-robin arbiter
package ocext_arb_pkg;
  localparam int MAX_PORTS = 32;
  localparam int MAX_WW = 16;
  localparam int FLAT_W = MAX_PORTS * MAX_WW;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [MAX_WW-1:0] weight_slice(input logic [FLAT_W-1:0] flat, input int i, input int ww);
    return MAX_WW'((flat >> (i * ww)) & ~({FLAT_W{1'b1}} << ww));
  endfunction
  function automatic logic [MAX_WW-1:0] clamp_one(input logic [MAX_WW-1:0] w);
    return (w == '0) ? MAX_WW'(1) : w;
  endfunction
endpackage

// File: rtl/ocext_wrr_arbiter_if.sv
// ocext_wrr_arbiter_if: request/weight/beat inputs and registered grant outputs
interface ocext_wrr_arbiter_if #(
  parameter int PORTS = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(PORTS);
  logic [PORTS-1:0] request;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic xfer;
  logic last;
  logic [PORTS-1:0] grant;
  logic grant_valid;
  logic [IDX_W-1:0] grant_encoded;
  modport master (output request, weight, xfer, last, input grant, grant_valid, grant_encoded);
  modport slave (input request, weight, xfer, last, output grant, grant_valid, grant_encoded);
endinterface

// File: rtl/ocext_priority_encoder.sv
// ocext_priority_encoder: index of the highest-priority set request bit
module ocext_priority_encoder #(
  parameter int WIDTH = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);
  assign valid_o = |req_i;
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < WIDTH; k++)
      if (req_i[LSB_HIGH_PRIORITY ? WIDTH-1-k : k]) idx_o = IDX_W'(LSB_HIGH_PRIORITY ? WIDTH-1-k : k);
  end
endmodule

// File: rtl/ocext_wrr_arbiter.sv
// ocext_wrr_arbiter: weighted round-robin grant with zero-bubble handover
module ocext_wrr_arbiter
  import ocext_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int WEIGHT_W = 4
) (
  input logic                clk,
  input logic                rst,
  ocext_wrr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(PORTS);
  state_e state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d, mask;
  logic valid_q, valid_d;
  logic [IDX_W-1:0] enc_q, enc_d, rr_ptr_q, rr_ptr_d, ptr_eff, m_idx, r_idx, pick_idx;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic m_valid, r_valid, pick_valid, rel, load, clear;
  // while granted, a pick is only used on release, when rr_ptr becomes the granted port
  always_comb begin
    ptr_eff = (state_q == GRANT) ? enc_q : rr_ptr_q;
    mask = '0;
    for (int k = 0; k < PORTS; k++) mask[k] = k > int'(ptr_eff);
  end
  ocext_priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(1'b1)) u_pe_masked (
    .req_i(bus.request & mask), .valid_o(m_valid), .idx_o(m_idx));
  ocext_priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(1'b1)) u_pe_raw (
    .req_i(bus.request), .valid_o(r_valid), .idx_o(r_idx));
  assign pick_valid = m_valid | r_valid;
  assign pick_idx = m_valid ? m_idx : r_idx;
  assign rel = (state_q == GRANT) && (bus.xfer ? (bus.last || credit_q == WEIGHT_W'(1)) : !bus.request[enc_q]);
  assign load = (state_q == IDLE || rel) && pick_valid;
  assign clear = rel && !pick_valid;
  always_comb begin
    state_d = load ? GRANT : (clear ? IDLE : state_q);
    grant_d = load ? (PORTS'(1) << pick_idx) : (clear ? '0 : grant_q);
    valid_d = load | (valid_q & ~clear);
    enc_d = load ? pick_idx : enc_q;
    credit_d = load ? WEIGHT_W'(clamp_one(weight_slice(FLAT_W'(bus.weight), int'(pick_idx), WEIGHT_W)))
             : ((state_q == GRANT && bus.xfer) ? credit_q - WEIGHT_W'(1) : credit_q);
    rr_ptr_d = rel ? enc_q : rr_ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q <= '0;
      credit_q <= '0;
      rr_ptr_q <= IDX_W'(PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q <= enc_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_encoded = enc_q;
endmodule

// File: tb/tb_ocext_wrr_arbiter.sv
// tb_ocext_wrr_arbiter: scoreboard bench for the weighted round-robin arbiter
module tb_ocext_wrr_arbiter;
  localparam int PORTS = 4;
  localparam int WEIGHT_W = 4;
  localparam int BOUND = (PORTS - 1) * 15;
  localparam int SEQ1[6] = '{1, 1, 3, 3, 1, 1};
  typedef struct packed {
    logic v;
    logic [PORTS-1:0] g;
    logic [1:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic m_valid;
  int m_enc, m_credit, m_ptr;
  int wait_beats[PORTS];
  logic [PORTS-1:0] served;
  ocext_wrr_arbiter_if #(.PORTS(PORTS), .WEIGHT_W(WEIGHT_W)) bus ();
  ocext_wrr_arbiter #(.PORTS(PORTS), .WEIGHT_W(WEIGHT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [PORTS-1:0] r, input int ptr);
    for (int k = 1; k <= PORTS; k++) if (r[(ptr + k) % PORTS]) return (ptr + k) % PORTS;
    return -1;
  endfunction

  function automatic int weight_of(input int p);
    int w;
    w = int'(bus.weight[p*WEIGHT_W +: WEIGHT_W]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_enc = 0;
    m_credit = 0;
    m_ptr = PORTS - 1;
    served = '0;
    for (int i = 0; i < PORTS; i++) wait_beats[i] = 0;
    sb.delete();
  endtask

  task automatic step(input logic [PORTS-1:0] r, input logic x, input logic l);
    bit rel;
    int p;
    exp_t e;
    bus.request = r;
    bus.xfer = x;
    bus.last = l;
    for (int i = 0; i < PORTS; i++)
      if (!r[i]) wait_beats[i] = 0;
      else if (x && bus.grant_valid && int'(bus.grant_encoded) != i) wait_beats[i]++;
    rel = m_valid && (x ? (l || m_credit == 1) : !r[m_enc]);
    if (m_valid && x) m_credit--;
    if (rel) m_ptr = m_enc;
    if (!m_valid || rel) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_valid = 1'b1;
        m_enc = p;
        m_credit = weight_of(p);
        served[p] = 1'b1;
      end else m_valid = 1'b0;
    end
    e.v = m_valid;
    e.g = m_valid ? (PORTS'(1) << m_enc) : '0;
    e.idx = 2'(m_enc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("valid", bus.grant_valid, e.v);
      check("grant", bus.grant, e.g);
      if (e.v) check("enc", bus.grant_encoded, e.idx);
    end
    check("onehot", $onehot0(bus.grant), 1);
    check("valid_or", bus.grant_valid, |bus.grant);
    if (bus.grant_valid) check("enc_match", bus.grant[bus.grant_encoded], 1);
    for (int i = 0; i < PORTS; i++)
      if (bus.grant_valid && int'(bus.grant_encoded) == i) begin
        if (wait_beats[i] != 0) check("wait", wait_beats[i] <= BOUND, 1);
        wait_beats[i] = 0;
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.request = '0;
    bus.xfer = 1'b0;
    bus.last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_valid", bus.grant_valid, 0);
    check("rst_enc", bus.grant_encoded, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic random_phase(input int cycles);
    logic [PORTS-1:0] r;
    for (int c = 0; c < cycles; c++) begin
      r = bus.request;
      for (int i = 0; i < PORTS; i++)
        if (!r[i]) begin
          r[i] = ($urandom_range(3) == 0);
          served[i] = 1'b0;
        end else if (m_valid && m_enc == i) begin
          if ($urandom_range(15) == 0) r[i] = 1'b0;
        end else if (served[i] && $urandom_range(1) == 0) r[i] = 1'b0;
      bus.weight = 16'($urandom);
      step(r, $urandom_range(3) != 0, $urandom_range(7) == 0);
    end
  endtask

  initial begin
    bus.weight = {4{4'd2}};
    model_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1010, 1'b1, 1'b0);
      check("t1_seq", bus.grant_encoded, SEQ1[i]);
      check("t1_nobubble", bus.grant_valid, 1);
    end
    do_reset();
    bus.weight = {4'd2, 4'd0, 4'd2, 4'd2};
    repeat (4) begin
      step(4'b0100, 1'b1, 1'b0);
      check("t2_w0", bus.grant, 4'b0100);
    end
    do_reset();
    bus.weight = {4'd2, 4'd2, 4'd2, 4'd8};
    step(4'b0011, 1'b0, 1'b0);
    check("t3_g0", bus.grant, 4'b0001);
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    check("t3_hold", bus.grant, 4'b0001);
    step(4'b0011, 1'b1, 1'b1);
    check("t3_last", bus.grant, 4'b0010);
    do_reset();
    bus.weight = {4{4'd2}};
    step(4'b0010, 1'b0, 1'b0);
    check("t4_g1", bus.grant, 4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    check("t4_idle", bus.grant_valid, 0);
    step(4'b0011, 1'b0, 1'b0);
    check("t4_ptr", bus.grant, 4'b0001);
    step(4'b0110, 1'b0, 1'b0);
    check("t4_abandon", bus.grant, 4'b0010);
    do_reset();
    bus.weight = {4'd3, 4'd2, 4'd2, 4'd2};
    step(4'b1000, 1'b0, 1'b0);
    check("t5_g3", bus.grant, 4'b1000);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_grant", bus.grant, 0);
    check("t5_async_valid", bus.grant_valid, 0);
    check("t5_async_enc", bus.grant_encoded, 0);
    #2;
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1'b0, 1'b0);
    check("t5_port0", bus.grant, 4'b0001);
    do_reset();
    random_phase(10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ocext_wrr_arbiter.md
Name: ocext_wrr_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource (bus, FIFO write port, memory channel) between PORTS requesters.
- Holds a grant for up to weight[i] accepted beats, or until the requester signals last, then passes the grant to the next requester in round-robin order.
- Sits in front of stream muxes and shared-port datapaths where plain round robin starves long bursts or over-serves short ones.
- Re-arbitrates with zero bubble cycles.

Parameters:
- PORTS, 4, number of requesters (≥2).
- WEIGHT_W, 4, width of each per-port weight and of the credit counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- request  input  PORTS  per-port request; held high until served.
- weight  input  PORTS*WEIGHT_W  per-port max beats per grant; port i uses bits [i*WEIGHT_W +: WEIGHT_W]. Value 0 is treated as 1.
- xfer  input  1  one beat accepted for the currently granted port this cycle.
- last  input  1  qualifies xfer; final beat of the granted requester's packet.
- grant  output  PORTS  one-hot grant, registered.
- grant_valid  output  1  a grant is active, registered.
- grant_encoded  output  $clog2(PORTS)  index of the granted port, registered.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: grant=0, grant_valid=0, grant_encoded=0, credit=0, state=IDLE, rr_ptr=PORTS-1. After reset, port 0 has top priority.
- Priority order: from rr_ptr+1 upward, wrapping modulo PORTS. The port at rr_ptr is lowest priority.
- Latency: a request seen in IDLE produces a grant on the next clock edge.
- State IDLE:
  - If any request bit is set: pick port p by the priority order.
  - Register grant=1<<p, grant_valid=1, grant_encoded=p.
  - Load credit = max(weight[p],1). Weight is sampled only at grant time.
  - Move to GRANT.
- State GRANT:
  - On xfer: credit decrements by 1.
  - Release occurs when (xfer && last), or (xfer && credit==1), or (!request[grant_encoded] && !xfer). The last case is abandonment.
  - On release: rr_ptr ← grant_encoded.
  - Same cycle as release: pick the next port from the current request vector using the updated rr_ptr. The released port is eligible only if no other port requests.
  - If a port is picked: load the new grant and credit next cycle and stay in GRANT (zero bubble).
  - If nothing is picked: grant=0, grant_valid=0, go to IDLE.
- xfer while in IDLE, or with grant_valid=0, is ignored. last without xfer is ignored.
- Credit never underflows. The release condition fires at credit==1, so credit never reaches 0 while in GRANT.
- Request bits of non-granted ports may change freely. They affect only the next pick.
- Reset asserted mid-burst clears all outputs immediately, without waiting for a clock edge. rr_ptr returns to PORTS-1.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_encoded matches grant whenever grant_valid=1.

Decomposition:
- Shared package ocext_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the function that extracts port i's weight slice;
  - the weight-zero-as-one clamp function.
- Sub-module: the round-robin pick is built from two ocext_priority_encoder instances with LSB_HIGH_PRIORITY=1.
  - One instance sees request & mask, where mask is the bits above rr_ptr.
  - The other sees the raw request vector.
  - The masked result wins if valid.
- Target size: about 200 lines of RTL.

Test Plan:
- Reset then request=4'b1010, all weights=2, xfer held high, last=0: grant sequence is port1 ×2 beats, port3 ×2, port1 ×2. No idle cycle between grants.
- weight=0 on port2 only, request=4'b0100, xfer each cycle: grant released after 1 beat, then re-granted to port2 (sole requester) with no bubble.
- Port0 weight=8, request=4'b0011, xfer each cycle, last on the 3rd beat: port0 held exactly 3 beats, then port1 granted.
- Port1 granted, request[1] drops with xfer=0: grant moves next cycle to the next requester, or grant_valid=0 if none; rr_ptr=1.
- Port3 granted with credit=3, rst asserted asynchronously between edges: grant, grant_valid and grant_encoded go to 0 before the next edge. After release, request=4'b1111 gives port0 first.
- Random request/xfer/last for 10k cycles: check the one-hot invariant. Check no port waits more than (PORTS-1)×max(weight) xfer beats while its request is held.
